// File: rtl/bracket_scan_unit.sv
// Bracket scan unit: walks instruction memory from a CBF/CBB to its matching bracket.
// Optional direct-mapped target cache enabled by defining BRACKET_SCAN_CACHE_EN.
module bracket_scan_unit #(
  parameter int                 PC_W          = 16,
  parameter int                 INSTR_W       = 9,
  parameter int                 DEPTH_W       = 8,
  parameter logic [INSTR_W-1:0] CBF_CODE      = 9'b001000000,
  parameter logic [INSTR_W-1:0] CBB_CODE      = 9'b010000000,
  parameter int                 CACHE_ENTRIES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               dir,
  input  logic [PC_W-1:0]    start_pc,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [PC_W-1:0]    target_pc,
  output logic               fetch_en,
  output logic [PC_W-1:0]    fetch_addr,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               flush
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  localparam logic [PC_W-1:0]    PC_MAX    = {PC_W{1'b1}};
  localparam logic [PC_W-1:0]    PC_ONE    = 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = 1;

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [PC_W-1:0]     issue_q, issue_d;
  logic                pend_q, pend_d;
  logic [PC_W-1:0]     pend_addr_q, pend_addr_d;
  logic                stop_q, stop_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [PC_W-1:0]     target_q, target_d;
  logic                scan_match;
  logic                cache_hit;
  logic [PC_W-1:0]     cache_target;
  logic [INSTR_W-1:0]  same_code, opp_code;

  assign same_code  = dir_q ? CBB_CODE : CBF_CODE;
  assign opp_code   = dir_q ? CBF_CODE : CBB_CODE;
  assign busy       = (state_q == SCAN);
  assign fetch_en   = (state_q == SCAN) && !stop_q;
  assign fetch_addr = issue_q;
  assign done       = done_q;
  assign error      = error_q;
  assign target_pc  = target_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      issue_q     <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      stop_q      <= 1'b0;
      depth_q     <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      target_q    <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      issue_q     <= issue_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      stop_q      <= stop_d;
      depth_q     <= depth_d;
      done_q      <= done_d;
      error_q     <= error_d;
      target_q    <= target_d;
    end
  end

  // Issue side prefetches one address per cycle; check side judges the word fetched
  // last cycle. stop_q means the wrap boundary was issued, so nothing further follows.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    issue_d     = issue_q;
    pend_d      = 1'b0;
    pend_addr_d = pend_addr_q;
    stop_d      = stop_q;
    depth_d     = depth_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    target_d    = target_q;
    scan_match  = 1'b0;
    case (state_q)
      SCAN: begin
        if (!stop_q) begin
          pend_d      = 1'b1;
          pend_addr_d = issue_q;
          issue_d     = dir_q ? issue_q - PC_ONE : issue_q + PC_ONE;
          stop_d      = dir_q ? (issue_q == '0) : (issue_q == PC_MAX);
        end
        if (pend_q && instr_in == opp_code && depth_q == DEPTH_ONE) begin
          scan_match = 1'b1;
          done_d     = 1'b1;
          target_d   = pend_addr_q;
          state_d    = DRAIN;
        end else if (pend_q && instr_in == same_code && depth_q == DEPTH_MAX) begin
          error_d = 1'b1;
          state_d = DRAIN;
        end else begin
          if (pend_q && instr_in == opp_code) begin
            depth_d = depth_q - DEPTH_ONE;
          end else if (pend_q && instr_in == same_code) begin
            depth_d = depth_q + DEPTH_ONE;
          end
          if (stop_q) begin
            error_d = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          if (cache_hit) begin
            done_d   = 1'b1;
            target_d = cache_target;
          end else begin
            state_d = SCAN;
            dir_d   = dir;
            depth_d = DEPTH_ONE;
            issue_d = dir ? start_pc - PC_ONE : start_pc + PC_ONE;
            stop_d  = dir ? (start_pc == '0) : (start_pc == PC_MAX);
          end
        end
      end
    endcase
  end

`ifdef BRACKET_SCAN_CACHE_EN
  localparam int IDX_W = (CACHE_ENTRIES > 1) ? $clog2(CACHE_ENTRIES) : 1;

  logic [CACHE_ENTRIES-1:0] valid_q;
  logic [PC_W:0]            tag_q    [CACHE_ENTRIES];
  logic [PC_W-1:0]          ctgt_q   [CACHE_ENTRIES];
  logic [PC_W-1:0]          origin_q;
  logic [IDX_W-1:0]         rd_idx, wr_idx;

  assign rd_idx       = start_pc[IDX_W-1:0];
  assign wr_idx       = origin_q[IDX_W-1:0];
  assign cache_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == {dir, start_pc});
  assign cache_target = ctgt_q[rd_idx];

  // Flush has priority over a same-cycle fill so no stale target survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      origin_q <= '0;
    end else begin
      if (state_q != SCAN && start) origin_q <= start_pc;
      if (flush) valid_q <= '0;
      else if (scan_match) valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (scan_match) begin
      tag_q[wr_idx]  <= {dir_q, origin_q};
      ctgt_q[wr_idx] <= target_d;
    end
  end
`else
  logic unused_flush;
  localparam int unused_cache_entries = CACHE_ENTRIES;
  assign unused_flush = flush;
  assign cache_hit    = 1'b0;
  assign cache_target = '0;
`endif

endmodule

// File: tb/tb_bracket_scan_unit.sv
// Directed bench for bracket_scan_unit (DEPTH_W=2 so overflow is reachable quickly).
// Cache scenario runs only when BRACKET_SCAN_CACHE_EN is defined.
module tb_bracket_scan_unit;

  localparam logic [8:0] CBF = 9'b001000000;
  localparam logic [8:0] CBB = 9'b010000000;
  localparam logic [8:0] INC = 9'b000000001;
  localparam logic [8:0] NOP = 9'b000000000;

  logic        clk = 1'b0;
  logic        rst_n, start, dir, flush;
  logic [15:0] start_pc;
  logic        busy, done, error, fetch_en;
  logic [15:0] target_pc, fetch_addr;
  logic [8:0]  instr_in;

  logic [8:0]  mem [0:65535];
  logic [15:0] fetchLog [$];
  int          errors = 0;
  int          checks = 0;

  bracket_scan_unit #(.DEPTH_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .start_pc(start_pc),
    .busy(busy), .done(done), .error(error), .target_pc(target_pc),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr), .instr_in(instr_in), .flush(flush)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data for a request appears one cycle later.
  always @(posedge clk) if (fetch_en) instr_in <= mem[fetch_addr];

  always @(negedge clk) if (rst_n && fetch_en) fetchLog.push_back(fetch_addr);

  task automatic startScan(input logic d, input logic [15:0] pc);
    @(negedge clk);
    fetchLog.delete();
    start = 1'b1; dir = d; start_pc = pc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitResult(input int fromCyc, input int budget,
                            output int cyc, output bit gotDone, output bit gotErr);
    cyc = fromCyc; gotDone = 1'b0; gotErr = 1'b0;
    while (cyc <= budget) begin
      if (done === 1'b1 || error === 1'b1) begin
        gotDone = done; gotErr = error;
        return;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; flush = 1'b0; start_pc = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error got=%b exp=0", error); end
    checks++; if (fetch_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_en got=%b exp=0", fetch_en); end
    checks++; if (target_pc !== 16'h0) begin errors++; $display("[TB] FAIL reset_target got=%h exp=0000", target_pc); end
    checks++; if (fetch_addr !== 16'h0) begin errors++; $display("[TB] FAIL reset_fetch_addr got=%h exp=0000", fetch_addr); end
  endtask

  task automatic test_forward_simple();
    int cyc; bit gd, ge;
    mem[16'h11] = INC; mem[16'h12] = CBB;
    startScan(1'b0, 16'h0010);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL fwd_busy_t1 got=%b exp=1", busy); end
    waitResult(1, 20, cyc, gd, ge);
    checks++; if (cyc !== 4) begin errors++; $display("[TB] FAIL fwd_done_cycle got=%0d exp=4", cyc); end
    checks++; if (gd !== 1'b1 || ge !== 1'b0) begin errors++; $display("[TB] FAIL fwd_done_err got=%b%b exp=10", gd, ge); end
    checks++; if (target_pc !== 16'h0012) begin errors++; $display("[TB] FAIL fwd_target got=%h exp=0012", target_pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL fwd_busy_at_done got=%b exp=0", busy); end
    checks++; if (fetchLog.size() !== 3) begin errors++; $display("[TB] FAIL fwd_fetch_count got=%0d exp=3", fetchLog.size()); end
    else if (fetchLog[0] !== 16'h11 || fetchLog[1] !== 16'h12 || fetchLog[2] !== 16'h13) begin
      errors++; $display("[TB] FAIL fwd_fetch_addrs got=%h,%h,%h exp=0011,0012,0013", fetchLog[0], fetchLog[1], fetchLog[2]);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL fwd_done_pulse got=%b exp=0", done); end
    checks++; if (target_pc !== 16'h0012) begin errors++; $display("[TB] FAIL fwd_target_hold got=%h exp=0012", target_pc); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nested_backward();
    int cyc; bit gd, ge;
    mem[16'h1F] = CBB; mem[16'h1E] = CBF; mem[16'h1D] = CBF;
    startScan(1'b1, 16'h0020);
    waitResult(1, 20, cyc, gd, ge);
    checks++; if (cyc !== 5) begin errors++; $display("[TB] FAIL bwd_done_cycle got=%0d exp=5", cyc); end
    checks++; if (gd !== 1'b1 || ge !== 1'b0) begin errors++; $display("[TB] FAIL bwd_done_err got=%b%b exp=10", gd, ge); end
    checks++; if (target_pc !== 16'h001D) begin errors++; $display("[TB] FAIL bwd_target got=%h exp=001d", target_pc); end
    checks++; if (fetchLog.size() < 1 || fetchLog[0] !== 16'h1F) begin errors++; $display("[TB] FAIL bwd_first_fetch got=%h exp=001f", (fetchLog.size() > 0) ? fetchLog[0] : 16'hxxxx); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap();
    int cyc; bit gd, ge;
    mem[16'hFFFE] = NOP; mem[16'hFFFF] = NOP;
    startScan(1'b0, 16'hFFFD);
    waitResult(1, 20, cyc, gd, ge);
    checks++; if (cyc !== 4) begin errors++; $display("[TB] FAIL wrap_error_cycle got=%0d exp=4", cyc); end
    checks++; if (ge !== 1'b1 || gd !== 1'b0) begin errors++; $display("[TB] FAIL wrap_err_done got=%b%b exp=10", ge, gd); end
    @(negedge clk);
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL wrap_error_pulse got=%b exp=0", error); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wrap_idle_busy got=%b exp=0", busy); end
    checks++; if (fetchLog.size() !== 2) begin errors++; $display("[TB] FAIL wrap_fetch_count got=%0d exp=2", fetchLog.size()); end
    else if (fetchLog[0] !== 16'hFFFE || fetchLog[1] !== 16'hFFFF) begin
      errors++; $display("[TB] FAIL wrap_fetch_addrs got=%h,%h exp=fffe,ffff", fetchLog[0], fetchLog[1]);
    end
  endtask

  task automatic test_overflow();
    int cyc; bit gd, ge;
    bit sawDone = 1'b0;
    for (int a = 16'h41; a <= 16'h44; a++) mem[a] = CBF;
    startScan(1'b0, 16'h0040);
    waitResult(1, 20, cyc, gd, ge);
    checks++; if (cyc !== 5) begin errors++; $display("[TB] FAIL ovf_error_cycle got=%0d exp=5", cyc); end
    checks++; if (ge !== 1'b1 || gd !== 1'b0) begin errors++; $display("[TB] FAIL ovf_err_done got=%b%b exp=10", ge, gd); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) sawDone = 1'b1;
    end
    checks++; if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL ovf_late_done got=%b exp=0", sawDone); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit gd, ge;
    mem[16'h51] = NOP; mem[16'h52] = CBB;
    startScan(1'b0, 16'h0050);
    start = 1'b1; dir = 1'b1; start_pc = 16'h0070;
    @(negedge clk);
    start = 1'b0;
    waitResult(2, 20, cyc, gd, ge);
    checks++; if (cyc !== 4) begin errors++; $display("[TB] FAIL b2b_done_cycle got=%0d exp=4", cyc); end
    checks++; if (target_pc !== 16'h0052) begin errors++; $display("[TB] FAIL b2b_target got=%h exp=0052", target_pc); end
    repeat (3) @(negedge clk);
    for (int a = 16'h81; a <= 16'h85; a++) mem[a] = NOP;
    mem[16'h86] = CBB;
    startScan(1'b0, 16'h0080);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (fetch_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_fetch_en got=%b exp=0", fetch_en); end
    checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("[TB] FAIL rst_done_err got=%b%b exp=00", done, error); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mem[16'h91] = CBB;
    startScan(1'b0, 16'h0090);
    waitResult(1, 20, cyc, gd, ge);
    checks++; if (cyc !== 3 || gd !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_done got=cyc%0d,%b exp=cyc3,1", cyc, gd); end
    checks++; if (target_pc !== 16'h0091) begin errors++; $display("[TB] FAIL post_rst_target got=%h exp=0091", target_pc); end
    repeat (3) @(negedge clk);
  endtask

`ifdef BRACKET_SCAN_CACHE_EN
  task automatic test_cache();
    int cyc; bit gd, ge;
    startScan(1'b0, 16'h0010);
    waitResult(1, 20, cyc, gd, ge);
    checks++; if (cyc !== 4) begin errors++; $display("[TB] FAIL cache_fill_cycle got=%0d exp=4", cyc); end
    repeat (3) @(negedge clk);
    startScan(1'b0, 16'h0010);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cache_hit_busy got=%b exp=0", busy); end
    waitResult(1, 20, cyc, gd, ge);
    checks++; if (cyc !== 1 || gd !== 1'b1) begin errors++; $display("[TB] FAIL cache_hit_done got=cyc%0d,%b exp=cyc1,1", cyc, gd); end
    checks++; if (target_pc !== 16'h0012) begin errors++; $display("[TB] FAIL cache_hit_target got=%h exp=0012", target_pc); end
    repeat (2) @(negedge clk);
    checks++; if (fetchLog.size() !== 0) begin errors++; $display("[TB] FAIL cache_hit_fetches got=%0d exp=0", fetchLog.size()); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    startScan(1'b0, 16'h0010);
    waitResult(1, 20, cyc, gd, ge);
    checks++; if (cyc !== 4 || target_pc !== 16'h0012) begin errors++; $display("[TB] FAIL cache_flush_rescan got=cyc%0d,%h exp=cyc4,0012", cyc, target_pc); end
    checks++; if (fetchLog.size() !== 3) begin errors++; $display("[TB] FAIL cache_flush_fetches got=%0d exp=3", fetchLog.size()); end
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = NOP;
    test_reset();
    test_forward_simple();
    test_nested_backward();
    test_wrap();
    test_overflow();
    test_back_to_back();
`ifdef BRACKET_SCAN_CACHE_EN
    test_cache();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Done and error must never coincide at any sample point.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1 && error === 1'b1) begin
      errors++;
      $display("[TB] FAIL done_error_exclusive got=11 exp=not both");
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
